// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline constants: EX operand mux select codes and hazard FSM states.
// The datapath operand muxes decode the same SEL_* codes.
package hazard_fwd_unit_pkg;

    localparam logic [1:0] SEL_RF    = 2'b00;
    localparam logic [1:0] SEL_EXMEM = 2'b01;
    localparam logic [1:0] SEL_MEMWB = 2'b10;
    localparam logic [1:0] SEL_IMM   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } fsm_state_e;

    // The younger producer (ID/EX) wins over the older one (EX/MEM).
    function automatic logic [1:0] pick_sel(input logic idex_hit, input logic exmem_hit);
        logic [1:0] sel;
        if (idex_hit) begin
            sel = SEL_EXMEM;
        end else if (exmem_hit) begin
            sel = SEL_MEMWB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_cmp.sv
// Per-operand forwarding comparator: matches one ID source index against the
// ID/EX and EX/MEM shadow tags and returns the register/forward select code.
module fwd_cmp
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_src,
    input  logic             i_use,
    input  logic [REG_W-1:0] i_idex_dest,
    input  logic             i_idex_rw,
    input  logic [REG_W-1:0] i_exmem_dest,
    input  logic             i_exmem_rw,
    output logic [1:0]       o_sel
);

    logic w_idex_hit;
    logic w_exmem_hit;

    // Register 0 is hardwired, so a write to it never produces a forward.
    assign w_idex_hit  = i_use && i_idex_rw && (i_idex_dest != {REG_W{1'b0}})
                         && (i_idex_dest == i_src);
    assign w_exmem_hit = i_use && i_exmem_rw && (i_exmem_dest != {REG_W{1'b0}})
                         && (i_exmem_dest == i_src);

    assign o_sel = pick_sel(w_idex_hit, w_exmem_hit);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for a 5-stage pipeline: registered
// EX operand selects, load-use stall / branch flush FSM and event counters.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_use_imm,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fsm_state_e       r_state;
    fsm_state_e       w_next_state;
    logic [REG_W-1:0] r_idex_dest;
    logic             r_idex_rw;
    logic             r_idex_load;
    logic [REG_W-1:0] r_exmem_dest;
    logic             r_exmem_rw;
    logic             r_exmem_load;
    logic [1:0]       r_fwd_a_sel;
    logic [1:0]       r_fwd_b_sel;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [1:0]       w_cmp_a;
    logic [1:0]       w_cmp_b;
    logic [1:0]       w_sel_b;
    logic             w_hazard;
    logic             w_stall;
    logic             w_bubble;
    logic             w_flush;

    fwd_cmp #(.REG_W(REG_W)) u_cmp_a (
        .i_src        (id_rs),
        .i_use        (id_use_rs),
        .i_idex_dest  (r_idex_dest),
        .i_idex_rw    (r_idex_rw),
        .i_exmem_dest (r_exmem_dest),
        .i_exmem_rw   (r_exmem_rw),
        .o_sel        (w_cmp_a)
    );

    fwd_cmp #(.REG_W(REG_W)) u_cmp_b (
        .i_src        (id_rt),
        .i_use        (id_use_rt),
        .i_idex_dest  (r_idex_dest),
        .i_idex_rw    (r_idex_rw),
        .i_exmem_dest (r_exmem_dest),
        .i_exmem_rw   (r_exmem_rw),
        .o_sel        (w_cmp_b)
    );

    assign w_sel_b = id_use_imm ? SEL_IMM : w_cmp_b;

    // A load in EX cannot supply its data in time for a dependent instruction in ID.
    assign w_hazard = id_valid && r_idex_load && r_idex_rw
                      && (r_idex_dest != {REG_W{1'b0}})
                      && (((r_idex_dest == id_rs) && id_use_rs)
                          || ((r_idex_dest == id_rt) && id_use_rt && !id_use_imm));

    // Next-state and stall/bubble/flush decode; a taken branch overrides the hazard.
    always_comb begin
        w_next_state = ST_RUN;
        w_stall      = 1'b0;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        if (!rst_n) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        w_flush      = 1'b1;
                        w_bubble     = 1'b1;
                        w_next_state = ST_FLUSH;
                    end else if (w_hazard) begin
                        w_stall      = 1'b1;
                        w_bubble     = 1'b1;
                        w_next_state = ST_STALL;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_STALL: begin
                    if (ex_branch_taken) begin
                        w_flush      = 1'b1;
                        w_bubble     = 1'b1;
                        w_next_state = ST_FLUSH;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (ex_branch_taken) begin
                        w_flush  = 1'b1;
                        w_bubble = 1'b1;
                    end else begin
                        w_flush  = 1'b0;
                    end
                    w_next_state = ST_RUN;
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Shadow tags follow the instruction down the pipe; a held or flushed ID becomes a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idex_dest  <= {REG_W{1'b0}};
            r_idex_rw    <= 1'b0;
            r_idex_load  <= 1'b0;
            r_exmem_dest <= {REG_W{1'b0}};
            r_exmem_rw   <= 1'b0;
            r_exmem_load <= 1'b0;
        end else begin
            r_exmem_dest <= r_idex_dest;
            r_exmem_rw   <= r_idex_rw;
            r_exmem_load <= r_idex_load;
            if (id_valid && !w_stall && !w_flush) begin
                r_idex_dest <= id_dest;
                r_idex_rw   <= id_regwrite;
                r_idex_load <= id_is_load;
            end else begin
                r_idex_dest <= {REG_W{1'b0}};
                r_idex_rw   <= 1'b0;
                r_idex_load <= 1'b0;
            end
        end
    end

    // Selects are registered so they line up with the instruction once it reaches EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fwd_a_sel <= SEL_RF;
            r_fwd_b_sel <= SEL_RF;
        end else if (w_stall || w_flush || !id_valid) begin
            r_fwd_a_sel <= SEL_RF;
            r_fwd_b_sel <= SEL_RF;
        end else begin
            r_fwd_a_sel <= w_cmp_a;
            r_fwd_b_sel <= w_sel_b;
        end
    end

    // Saturating stall/flush event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign fwd_a_sel = r_fwd_a_sel;
    assign fwd_b_sel = r_fwd_b_sel;
    assign stall     = w_stall;
    assign bubble    = w_bubble;
    assign flush     = w_flush;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit (CNT_W reduced to 4 so
// counter saturation is reachable in a short run).
module tb_hazard_fwd_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_use_imm;
    logic [4:0] id_dest;
    logic       id_regwrite;
    logic       id_is_load;
    logic       ex_branch_taken;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;

    int tests;
    int fails;

    hazard_fwd_unit #(.REG_W(5), .CNT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_use_imm      (id_use_imm),
        .id_dest         (id_dest),
        .id_regwrite     (id_regwrite),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall           (stall),
        .bubble          (bubble),
        .flush           (flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic uimm,
                          input logic [4:0] dest, input logic rw, input logic ld);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_use_rs   = urs;
        id_use_rt   = urt;
        id_use_imm  = uimm;
        id_dest     = dest;
        id_regwrite = rw;
        id_is_load  = ld;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ex_branch_taken = 1'b0;
        nop();
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_branch_taken = 1'b1;
        nop();
        tests++;
        if (flush !== 1'b0 || stall !== 1'b0 || bubble !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got flush=%b stall=%b bubble=%b expected 0 0 0", flush, stall, bubble);
        end
        step();
        step();
        tests++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            fails++;
            $display("FAIL reset_sel: got %b/%b expected 00/00", fwd_a_sel, fwd_b_sel);
        end
        tests++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
        end
        ex_branch_taken = 1'b0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fwd_exmem();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);   // add $3,$1,$2
        step();
        set_id(1'b1, 5'd3, 5'd6, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);   // sub $4,$3,$6
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL alu_no_stall: got %b expected 0", stall);
        end
        step();
        tests++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
            fails++;
            $display("FAIL fwd_a_exmem: got %b/%b expected 01/00", fwd_a_sel, fwd_b_sel);
        end
        nop();
        step();
        tests++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            fails++;
            $display("FAIL nop_sel: got %b/%b expected 00/00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_fwd_memwb();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);   // add $3
        step();
        nop();
        step();
        set_id(1'b1, 5'd8, 5'd3, 1'b1, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);   // or $7,$8,$3
        step();
        tests++;
        if (fwd_b_sel !== 2'b10 || fwd_a_sel !== 2'b00) begin
            fails++;
            $display("FAIL fwd_b_memwb: got %b/%b expected 00/10", fwd_a_sel, fwd_b_sel);
        end
        // Two in-flight writers of $3: the younger one must win.
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd4, 5'd5, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        step();
        tests++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
            fails++;
            $display("FAIL fwd_priority: got %b/%b expected 01/01", fwd_a_sel, fwd_b_sel);
        end
        // Writer three instructions older is in WB: register file supplies it.
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        step();
        nop();
        step();
        step();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
        step();
        tests++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            fails++;
            $display("FAIL wb_writethrough: got %b/%b expected 00/00", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);  // lw $5,0($29)
        step();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);   // add $6,$5,$7
        tests++;
        if (stall !== 1'b1 || bubble !== 1'b1 || flush !== 1'b0) begin
            fails++;
            $display("FAIL lu_stall: got stall=%b bubble=%b flush=%b expected 1 1 0", stall, bubble, flush);
        end
        step();
        tests++;
        if (stall !== 1'b0 || fwd_a_sel !== 2'b00 || stall_cnt !== 4'd1) begin
            fails++;
            $display("FAIL lu_hold: got stall=%b sel=%b cnt=%0d expected 0 00 1", stall, fwd_a_sel, stall_cnt);
        end
        step();
        tests++;
        if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b00 || stall_cnt !== 4'd1) begin
            fails++;
            $display("FAIL lu_fwd: got %b/%b cnt=%0d expected 10/00 cnt=1", fwd_a_sel, fwd_b_sel, stall_cnt);
        end
        // Same dependency but ID is not valid: no stall.
        do_reset();
        set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        step();
        set_id(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL invalid_no_stall: got %b expected 0", stall);
        end
        // Dependency only through rt while B uses the immediate: no stall.
        set_id(1'b1, 5'd9, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL imm_no_stall: got %b expected 0", stall);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        tests++;
        if (flush !== 1'b1 || stall !== 1'b0 || bubble !== 1'b1) begin
            fails++;
            $display("FAIL br_ctrl: got flush=%b stall=%b bubble=%b expected 1 0 1", flush, stall, bubble);
        end
        step();
        ex_branch_taken = 1'b0;
        nop();
        tests++;
        if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            fails++;
            $display("FAIL br_cnt: got flush_cnt=%0d stall_cnt=%0d expected 1 0", flush_cnt, stall_cnt);
        end
        tests++;
        if (flush !== 1'b0 || stall !== 1'b0 || fwd_a_sel !== 2'b00) begin
            fails++;
            $display("FAIL br_after: got flush=%b stall=%b sel=%b expected 0 0 00", flush, stall, fwd_a_sel);
        end
    endtask

    task automatic test_zero_and_imm();
        do_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);   // add $0
        step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);   // reads $0,$0
        step();
        tests++;
        if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            fails++;
            $display("FAIL zero_no_fwd: got %b/%b expected 00/00", fwd_a_sel, fwd_b_sel);
        end
        set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);   // addi $8,$4,imm
        step();
        tests++;
        if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b11) begin
            fails++;
            $display("FAIL imm_sel: got %b/%b expected 01/11", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_saturate_and_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
            step();
            set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
            step();
            nop();
            step();
            if (i == 13) begin
                tests++;
                if (stall_cnt !== 4'd14) begin
                    fails++;
                    $display("FAIL sat_count14: got %0d expected 14", stall_cnt);
                end
            end
        end
        tests++;
        if (stall_cnt !== 4'd15 || flush_cnt !== 4'd0) begin
            fails++;
            $display("FAIL sat_hold: got stall_cnt=%0d flush_cnt=%0d expected 15 0", stall_cnt, flush_cnt);
        end
        set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        tests++;
        if (stall !== 1'b0 || bubble !== 1'b0) begin
            fails++;
            $display("FAIL rst_gate: got stall=%b bubble=%b expected 0 0", stall, bubble);
        end
        rst_n = 1'b1;
        #1;
        step();
        rst_n = 1'b0;
        step();
        tests++;
        if (stall !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            fails++;
            $display("FAIL rst_mid_stall: got stall=%b cnt=%0d/%0d expected 0 0/0", stall, stall_cnt, flush_cnt);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (stall !== 1'b0) begin
            fails++;
            $display("FAIL rst_release: got stall=%b expected 0", stall);
        end
        step();
        tests++;
        if (stall !== 1'b0 || stall_cnt !== 4'd0 || fwd_a_sel !== 2'b00) begin
            fails++;
            $display("FAIL post_rst: got stall=%b cnt=%0d sel=%b expected 0 0 00", stall, stall_cnt, fwd_a_sel);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        ex_branch_taken = 1'b0;
        nop();
        test_reset();
        test_fwd_exmem();
        test_fwd_memwb();
        test_load_use();
        test_branch_priority();
        test_zero_and_imm();
        test_saturate_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
